sync_frame_tx: RTL
==================

Name: sync_frame_tx

Overview:
- Transmit-side counterpart of the correlation sync detector.
- Builds the framed sample stream that the receiver correlates against: a known BPSK m-sequence sync burst at every sync period, followed by payload samples taken from upstream with a valid/ready handshake.
- Sits between the payload source (modulator/mapper) and the DAC/TX filter chain.
- Uses the same time_sop / sync_mode period semantics as the receiver, so both ends agree on sync spacing.

Parameters:
- pDAT_W, 12: sample width (two's complement).
- pSYNC_Len, 1024: sync burst length in samples.
- pLFSR_W, 11: LFSR width.
- pLFSR_Poly, 11'h500: Galois feedback taps.
- pLFSR_Seed, 11'h001: LFSR value loaded at every burst start; must be nonzero.

Ports:
- iclk  in  1  clock.
- ireset  in  1  async active-low reset.
- iena  in  1  framer enable.
- sync_mode  in  1  1 = sync period doubled.
- time_sop  in  19  base sync period in samples.
- iamp  in  pDAT_W-1  sync amplitude magnitude (unsigned).
- idat  in  pDAT_W  payload sample.
- idat_val  in  1  payload valid.
- ordy  out  1  payload ready.
- odat  out  pDAT_W  output sample.
- oval  out  1  output sample valid.
- osop  out  1  first sync sample of a frame.
- osync_act  out  1  odat carries sync.
- ofrm_cnt  out  16  frames sent.
- ounderrun  out  1  sticky: payload missing in DATA.

Behaviour:
- Reset: every output 0, including odat, oval, osop, osync_act, ordy, ofrm_cnt, ounderrun. FSM = IDLE, LFSR = pLFSR_Seed.
- Clock enable: iclk is the sample clock. While not IDLE, exactly one sample is output per clock.
- Period: per_eff = sync_mode ? {time_sop,1'b0} : {1'b0,time_sop}, 20 bits.
  - Latched into per_lat when the FSM enters SYNC.
  - Changes to time_sop or sync_mode mid-frame take effect at the next frame.
  - data_len = per_lat - pSYNC_Len. If per_eff <= pSYNC_Len, data_len = 0 and bursts run back-to-back.
- FSM states: IDLE, SYNC, DATA.
  - IDLE -> SYNC: iena sampled high. cnt = 0, LFSR = seed, per_lat loaded.
  - SYNC: cnt counts 0..pSYNC_Len-1 and the LFSR steps once per cycle. At cnt == pSYNC_Len-1, go to DATA with cnt = 0; if data_len == 0, restart SYNC instead (reseed, relatch).
  - DATA: cnt counts 0..data_len-1. At the last count, go to SYNC (reseed, relatch per_eff).
  - Any state -> IDLE: iena low, the same cycle it is sampled. Outputs are zeroed at the next edge. A partial frame is abandoned, not completed.
- Output pipeline: one register stage. The sample decided in the cycle at state/cnt X appears on odat at the next edge.
  - oval = 1 for every sample produced from SYNC or DATA.
- Sync sample: LFSR LSB = 1 -> +iamp, 0 -> -iamp, sign-extended to pDAT_W.
  - iamp is sampled per sample; hold it constant during a burst.
- Payload handshake:
  - ordy = 1 combinationally while in DATA and iena is high.
  - A transfer happens when idat_val && ordy. That idat appears on odat next clock.
  - DATA cycle with idat_val = 0: odat = 0, the slot is consumed (never stretched), ounderrun set.
- osop: 1 together with the first sync sample (burst cnt 0) on odat. osync_act is 1 for all pSYNC_Len sync samples.
- ofrm_cnt: increments by 1 on each osop and wraps 0xFFFF -> 0. Cleared only by reset.
- ounderrun: sticky. Cleared by reset or by an iena rising edge.
- Timing contract: consecutive osop pulses are exactly per_eff clocks apart, or pSYNC_Len when per_eff <= pSYNC_Len, matching the receiver's cnt_time_sop expectation.

Test Plan:
- Reset release then iena = 1, pSYNC_Len = 16, time_sop = 40, sync_mode = 0, iamp = 100, idat_val held 1 -> first odat one clock after iena is sampled, with osop = 1. Samples are ±100 following the LFSR from seed 1. osync_act high 16 clocks, ordy high 24 clocks, next osop 40 clocks later, ofrm_cnt = 1 then 2.
- Same setup with sync_mode = 1 -> osop spacing 80 and 64 payload transfers per frame. Toggle sync_mode mid-DATA -> the current frame keeps its old length and the change applies to the next frame.
- Drop idat_val for 3 DATA cycles -> odat = 0 in exactly those 3 slots, frame length unchanged, ounderrun = 1 and sticky until iena toggles 0 -> 1.
- time_sop = 10 (less than 16) -> back-to-back 16-sample bursts, ordy never high, osop every 16 clocks, identical sequence each burst.
- Deassert iena at burst sample 7 -> oval = 0 and odat = 0 from the next edge. Re-enable -> a fresh burst starts from the seed with osop.
- Assert ireset mid-DATA -> all outputs 0 and ofrm_cnt = 0 immediately. After release with iena = 1, normal framing resumes.

Source files
------------

// File: rtl/sync_frame_tx.sv
// Sync framer: emits a BPSK m-sequence sync burst each period, then payload samples from upstream.
// Latency: one register stage; the sample decided at state/cnt X appears on odat at the next edge.
// Backpressure: ordy is high only in DATA. A missing payload leaves a zero slot and sets sticky ounderrun.
module sync_frame_tx #(
  parameter int                   pDAT_W     = 12,
  parameter int                   pSYNC_Len  = 1024,
  parameter int                   pLFSR_W    = 11,
  parameter logic [pLFSR_W-1:0]   pLFSR_Poly = 11'h500,
  parameter logic [pLFSR_W-1:0]   pLFSR_Seed = 11'h001
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iena,
  input  logic              sync_mode,
  input  logic [18:0]       time_sop,
  input  logic [pDAT_W-2:0] iamp,
  input  logic [pDAT_W-1:0] idat,
  input  logic              idat_val,
  output logic              ordy,
  output logic [pDAT_W-1:0] odat,
  output logic              oval,
  output logic              osop,
  output logic              osync_act,
  output logic [15:0]       ofrm_cnt,
  output logic              ounderrun
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SYNC  = 2'd1;
  localparam logic [1:0]  ST_DATA  = 2'd2;
  localparam logic [19:0] SYNC_LEN = 20'(pSYNC_Len);

  logic [1:0]         state;
  logic [19:0]        cnt;
  logic [19:0]        per_lat;
  logic [19:0]        per_eff;
  logic [19:0]        data_len;
  logic [pLFSR_W-1:0] lfsr;
  logic [pLFSR_W-1:0] lfsr_nxt;
  logic               iena_d;
  logic [pDAT_W-1:0]  amp_pos;
  logic [pDAT_W-1:0]  sync_smp;
  logic               sync_last;
  logic               data_last;

  // Same period rule as the receiver, so both ends agree on sync spacing.
  assign per_eff   = sync_mode ? {time_sop, 1'b0} : {1'b0, time_sop};
  // Periods no longer than a burst leave no payload room: bursts run back-to-back.
  assign data_len  = (per_lat > SYNC_LEN) ? (per_lat - SYNC_LEN) : 20'd0;
  assign sync_last = (cnt == SYNC_LEN - 20'd1);
  assign data_last = (cnt == data_len - 20'd1);

  // Right-shifting Galois LFSR; the LSB selects the BPSK symbol.
  assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ pLFSR_Poly) : (lfsr >> 1);
  assign amp_pos   = {1'b0, iamp};
  assign sync_smp  = lfsr[0] ? amp_pos : -amp_pos;

  assign ordy      = (state == ST_DATA) && iena;

  // Frame sequencer: IDLE -> SYNC burst -> DATA payload -> SYNC ..., dropping to IDLE whenever iena is low.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      per_lat <= '0;
      lfsr    <= pLFSR_Seed;
    end else if (!iena) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_SYNC;
          cnt     <= '0;
          lfsr    <= pLFSR_Seed;
          per_lat <= per_eff;
        end
        ST_SYNC: begin
          lfsr <= lfsr_nxt;
          if (sync_last) begin
            cnt <= '0;
            if (data_len == 20'd0) begin
              lfsr    <= pLFSR_Seed;
              per_lat <= per_eff;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        ST_DATA: begin
          if (data_last) begin
            state   <= ST_SYNC;
            cnt     <= '0;
            lfsr    <= pLFSR_Seed;
            per_lat <= per_eff;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: one sample per clock while framing, all zero otherwise; frame and underrun bookkeeping.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      odat      <= '0;
      oval      <= 1'b0;
      osop      <= 1'b0;
      osync_act <= 1'b0;
      ofrm_cnt  <= '0;
      ounderrun <= 1'b0;
      iena_d    <= 1'b0;
    end else begin
      iena_d    <= iena;
      odat      <= '0;
      oval      <= 1'b0;
      osop      <= 1'b0;
      osync_act <= 1'b0;
      if (iena && state == ST_SYNC) begin
        oval      <= 1'b1;
        odat      <= sync_smp;
        osync_act <= 1'b1;
        if (cnt == 20'd0) begin
          osop     <= 1'b1;
          ofrm_cnt <= ofrm_cnt + 16'd1;
        end
      end else if (ordy) begin
        oval <= 1'b1;
        odat <= idat_val ? idat : '0;
      end
      // A rising iena can only occur from IDLE, so it never competes with a new underrun.
      if (iena && !iena_d)
        ounderrun <= 1'b0;
      else if (ordy && !idat_val)
        ounderrun <= 1'b1;
    end
  end

endmodule
